// File: rtl/bg_copy_pkg.sv
// rtl/bg_copy_pkg.sv - shared state type and default sizes for the background copy engine
package bg_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    READ,
    WRITE,
    DONE
  } bg_copy_state_t;

  localparam int unsigned BG_IMG_WORDS_DEF = 153600;
  localparam int unsigned BG_STRIDE_DEF    = 307200;
  localparam int unsigned BG_NUM_DEF       = 4;

endpackage

// File: rtl/bg_copy_engine_if.sv
// rtl/bg_copy_engine_if.sv - SRAM read and framebuffer write handshakes of the copy engine
interface bg_copy_engine_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SRAM_AW = 20,
  parameter int unsigned OCM_AW  = 19
);
  logic               sram_rd_req;
  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_rd_ack;
  logic [DATA_W-1:0]  sram_rdata;
  logic               ocm_wr_req;
  logic [OCM_AW-1:0]  ocm_addr;
  logic [DATA_W-1:0]  ocm_wdata;
  logic               ocm_wr_ack;

  modport master (
    output sram_rd_req, sram_addr, ocm_wr_req, ocm_addr, ocm_wdata,
    input  sram_rd_ack, sram_rdata, ocm_wr_ack
  );

  modport slave (
    input  sram_rd_req, sram_addr, ocm_wr_req, ocm_addr, ocm_wdata,
    output sram_rd_ack, sram_rdata, ocm_wr_ack
  );
endinterface

// File: rtl/bg_addr_gen.sv
// rtl/bg_addr_gen.sv - latched background base, word index and derived SRAM/OCM addresses
module bg_addr_gen
  import bg_copy_pkg::*;
#(
  parameter int unsigned SRAM_AW   = 20,
  parameter int unsigned OCM_AW    = 19,
  parameter int unsigned NUM_BG    = BG_NUM_DEF,
  parameter int unsigned IMG_WORDS = BG_IMG_WORDS_DEF,
  parameter int unsigned BG_STRIDE = BG_STRIDE_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_acc,
  input  logic [$clog2(NUM_BG)-1:0]      bg_sel,
  input  logic                           load_base,
  input  logic                           step,
  output logic [SRAM_AW-1:0]             sram_addr,
  output logic [OCM_AW-1:0]              ocm_addr,
  output logic [$clog2(IMG_WORDS+1)-1:0] count,
  output logic                           last_word
);
  localparam int unsigned SEL_W = $clog2(NUM_BG);
  localparam int unsigned CNT_W = $clog2(IMG_WORDS + 1);

  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [CNT_W-1:0]   idx_q, idx_d;

  always_comb begin
    sel_d  = sel_q;
    base_d = base_q;
    idx_d  = idx_q;
    // Out-of-range selections fall back to background 0.
    if (start_acc) begin
      sel_d = (32'(bg_sel) < NUM_BG) ? bg_sel : '0;
      idx_d = '0;
    end
    if (load_base) base_d = SRAM_AW'(32'(sel_q) * BG_STRIDE);
    if (step)      idx_d  = idx_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      base_q <= '0;
      idx_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      base_q <= base_d;
      idx_q  <= idx_d;
    end
  end

  assign sram_addr = SRAM_AW'(32'(base_q) + 32'(idx_q));
  assign ocm_addr  = OCM_AW'(32'(idx_q) << 1);
  assign count     = idx_q;
  assign last_word = (32'(idx_q) == IMG_WORDS - 1);

endmodule

// File: rtl/bg_copy_engine.sv
// rtl/bg_copy_engine.sv - streams one background image from SRAM into the OCM framebuffer
// Optional BG_COPY_SENTINEL_EN: a read word >= SENTINEL terminates the copy early.
module bg_copy_engine
  import bg_copy_pkg::*;
#(
  parameter int unsigned        DATA_W    = 16,
  parameter int unsigned        SRAM_AW   = 20,
  parameter int unsigned        OCM_AW    = 19,
  parameter int unsigned        NUM_BG    = BG_NUM_DEF,
  parameter int unsigned        IMG_WORDS = BG_IMG_WORDS_DEF,
  parameter int unsigned        BG_STRIDE = BG_STRIDE_DEF,
  parameter logic [DATA_W-1:0]  SENTINEL  = 16'hF000
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [$clog2(NUM_BG)-1:0]      bg_sel,
  bg_copy_engine_if.master               mem,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted,
  output logic [$clog2(IMG_WORDS+1)-1:0] words_copied
);
  bg_copy_state_t    state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              aborted_q, aborted_d;
  logic              start_acc, load_base, step, last_word;

  bg_addr_gen #(
    .SRAM_AW  (SRAM_AW),
    .OCM_AW   (OCM_AW),
    .NUM_BG   (NUM_BG),
    .IMG_WORDS(IMG_WORDS),
    .BG_STRIDE(BG_STRIDE)
  ) u_addr_gen (
    .clk      (Clk),
    .rst      (Reset),
    .start_acc(start_acc),
    .bg_sel   (bg_sel),
    .load_base(load_base),
    .step     (step),
    .sram_addr(mem.sram_addr),
    .ocm_addr (mem.ocm_addr),
    .count    (words_copied),
    .last_word(last_word)
  );

`ifndef BG_COPY_SENTINEL_EN
  logic sentinel_unused;
  assign sentinel_unused = ^SENTINEL;
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    aborted_d = 1'b0;
    start_acc = 1'b0;
    load_base = 1'b0;
    step      = 1'b0;
    // Abort outranks any ack arriving in the same cycle, so that write is not counted.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = LATCH;
            start_acc = 1'b1;
          end
        end
        LATCH: begin
          load_base = 1'b1;
          state_d   = READ;
        end
        READ: begin
          if (mem.sram_rd_ack) begin
`ifdef BG_COPY_SENTINEL_EN
            if (mem.sram_rdata >= SENTINEL) begin
              state_d = DONE;
            end else begin
              data_d  = mem.sram_rdata;
              state_d = WRITE;
            end
`else
            data_d  = mem.sram_rdata;
            state_d = WRITE;
`endif
          end
        end
        WRITE: begin
          if (mem.ocm_wr_ack) begin
            step    = 1'b1;
            state_d = last_word ? DONE : READ;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      aborted_q <= aborted_d;
    end
  end

  assign mem.sram_rd_req = (state_q == READ);
  assign mem.ocm_wr_req  = (state_q == WRITE);
  assign mem.ocm_wdata   = data_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign aborted         = aborted_q;

endmodule

// File: tb/tb_bg_copy_engine.sv
// tb/tb_bg_copy_engine.sv - self-checking bench for bg_copy_engine with a 4-word image
module tb_bg_copy_engine;
  import bg_copy_pkg::*;

  localparam int unsigned IMG_WORDS = 4;
  localparam int unsigned STRIDE    = 307200;
`ifdef BG_COPY_SENTINEL_EN
  localparam bit SENT_EN = 1'b1;
`else
  localparam bit SENT_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] bg_sel = '0;
  logic       busy, done, aborted;
  logic [2:0] words_copied;

  bg_copy_engine_if #(.DATA_W(16), .SRAM_AW(20), .OCM_AW(19)) mem ();

  bg_copy_engine #(
    .DATA_W(16), .SRAM_AW(20), .OCM_AW(19), .NUM_BG(3),
    .IMG_WORDS(IMG_WORDS), .BG_STRIDE(STRIDE), .SENTINEL(16'hF000)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort), .bg_sel(bg_sel),
    .mem(mem), .busy(busy), .done(done), .aborted(aborted), .words_copied(words_copied)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  sel;
    int          rd_dly;
    int          wr_dly;
    int          ff_idx;
    logic [19:0] base;
  } vec_t;

  wr_t sb[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [1:0] sel, input int idx, input int ff_idx);
    if (idx == ff_idx) return 16'hFF00;
    return 16'h0A00 + (16'(sel) << 8) + 16'(idx);
  endfunction

  task automatic do_copy(input logic [1:0] sel, input int rd_dly, input int wr_dly,
                         input int ff_idx, input logic [19:0] base, input int abort_wr,
                         input bit disturb);
    int  rd_idx = 0, wr_cnt = 0, wait_c = 0, done_cyc = 0, exp_words, exp_writes;
    bit  finished = 0, got_done = 0, got_aborted = 0;
    wr_t e;
    sb.delete();
    exp_words  = (SENT_EN && ff_idx >= 0) ? ff_idx : int'(IMG_WORDS);
    if (abort_wr > 0) exp_words = abort_wr - 1;
    exp_writes = (abort_wr > 0) ? abort_wr : exp_words;

    @(negedge Clk);
    start  = 1'b1;
    bg_sel = sel;
    @(negedge Clk);
    start = 1'b0;
    check("latch_busy", busy, 1);
    check("latch_no_rd_req", mem.sram_rd_req, 0);

    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge Clk);
      mem.sram_rd_ack = 1'b0;
      mem.ocm_wr_ack  = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      if (disturb && c == 3) begin
        start  = 1'b1;
        bg_sel = 2'd3;
      end
      if (done) begin
        got_done = 1;
        finished = 1;
        done_cyc = c + 2;
        check("done_busy", busy, 1);
      end else if (aborted) begin
        got_aborted = 1;
        finished = 1;
        check("abort_idle", busy, 0);
        check("abort_req_drop", {mem.sram_rd_req, mem.ocm_wr_req}, 0);
      end else if (mem.sram_rd_req) begin
        check("rd_addr", mem.sram_addr, base + 20'(rd_idx));
        if (wait_c == rd_dly) begin
          mem.sram_rd_ack = 1'b1;
          mem.sram_rdata  = word_of(sel, rd_idx, ff_idx);
          if (!(SENT_EN && rd_idx == ff_idx))
            sb.push_back({19'(rd_idx * 2), mem.sram_rdata});
          rd_idx++;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end else if (mem.ocm_wr_req) begin
        check("sb_outstanding", sb.size(), 1);
        if (sb.size() > 0) begin
          check("wr_addr", mem.ocm_addr, sb[0].addr);
          check("wr_data", mem.ocm_wdata, sb[0].data);
        end
        if (wait_c == wr_dly) begin
          mem.ocm_wr_ack = 1'b1;
          wr_cnt++;
          wait_c = 0;
          if (wr_cnt == abort_wr) abort = 1'b1;
          if (sb.size() > 0) e = sb.pop_front();
        end else begin
          wait_c++;
        end
      end
    end
    mem.sram_rd_ack = 1'b0;
    mem.ocm_wr_ack  = 1'b0;
    abort = 1'b0;
    start = 1'b0;

    check("copy_finished", finished, 1);
    check("got_done", got_done, abort_wr == 0);
    check("got_aborted", got_aborted, abort_wr > 0);
    check("words_copied", words_copied, exp_words);
    check("write_count", wr_cnt, exp_writes);
    check("sb_empty", sb.size(), 0);
    if (rd_dly == 0 && wr_dly == 0 && abort_wr == 0 && exp_words == int'(IMG_WORDS))
      check("done_span", done_cyc + 1, 2 * IMG_WORDS + 3);
    @(negedge Clk);
    check("post_busy", busy, 0);
    check("post_pulses", {done, aborted}, 0);
    check("post_words_hold", words_copied, exp_words);
  endtask

  vec_t vecs[5];

  initial begin
    mem.sram_rd_ack = 1'b0;
    mem.sram_rdata  = '0;
    mem.ocm_wr_ack  = 1'b0;
    #3;
    check("rst_outputs", {busy, done, aborted, words_copied}, 0);
    check("rst_reqs", {mem.sram_rd_req, mem.ocm_wr_req, mem.sram_addr, mem.ocm_addr, mem.ocm_wdata}, 0);
    @(negedge Clk);
    Reset = 1'b0;

    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    check("idle_abort_ignored", {aborted, busy}, 0);

    vecs[0] = '{sel: 2'd2, rd_dly: 0, wr_dly: 0, ff_idx: -1, base: 20'd614400};
    vecs[1] = '{sel: 2'd0, rd_dly: 3, wr_dly: 0, ff_idx: -1, base: 20'd0};
    vecs[2] = '{sel: 2'd1, rd_dly: 0, wr_dly: 2, ff_idx: -1, base: 20'd307200};
    vecs[3] = '{sel: 2'd3, rd_dly: 1, wr_dly: 1, ff_idx: -1, base: 20'd0};
    vecs[4] = '{sel: 2'd1, rd_dly: 0, wr_dly: 0, ff_idx: 2,  base: 20'd307200};
    for (int i = 0; i < 5; i++)
      do_copy(vecs[i].sel, vecs[i].rd_dly, vecs[i].wr_dly, vecs[i].ff_idx, vecs[i].base, 0, 0);

    do_copy(2'd0, 0, 0, -1, 20'd0, 2, 0);
    do_copy(2'd2, 0, 1, -1, 20'd614400, 0, 1);

    @(negedge Clk);
    start  = 1'b1;
    bg_sel = 2'd1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    check("rst_seq_read", mem.sram_rd_req, 1);
    mem.sram_rd_ack = 1'b1;
    mem.sram_rdata  = 16'h1234;
    @(negedge Clk);
    mem.sram_rd_ack = 1'b0;
    check("rst_seq_write", mem.ocm_wr_req, 1);
    mem.ocm_wr_ack = 1'b1;
    @(negedge Clk);
    mem.ocm_wr_ack = 1'b0;
    check("rst_seq_pre", {mem.sram_rd_req, busy, words_copied}, {1'b1, 1'b1, 3'd1});
    #2 Reset = 1'b1;
    #1;
    check("async_rst_req", mem.sram_rd_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_words", words_copied, 0);
    @(negedge Clk);
    Reset = 1'b0;

    do_copy(2'd2, 0, 0, -1, 20'd614400, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
